// File: rtl/tbird_switch_conditioner.sv
// ----------------------------------------------------------------------------
// tbird_switch_conditioner
//
// Input stage for the T-bird tail-light sequencer. Each raw driver control
// (left, right, hazard, brake) is synchronised with two flops and debounced on
// its own. The debounced bits are encoded into the 3-bit code {brake, left,
// right} that the sequencer consumes. The block also produces a step tick
// that paces the light animation.
//
// Ports:
//   clock          in   system clock, every flop on the rising edge
//   reset_n        in   asynchronous active-low reset
//   raw_left       in   left-turn control, asynchronous to clock
//   raw_right      in   right-turn control, asynchronous to clock
//   raw_hazard     in   hazard control, asynchronous to clock
//   raw_brake      in   brake pedal, asynchronous to clock
//   switch         out  registered code {brake, left, right}
//   switch_changed out  one-cycle pulse on the cycle switch takes a new value
//   tick           out  one-cycle animation step enable
//
// Parameters:
//   DEB_CYCLES     consecutive synchronised cycles an input must differ from
//                  its debounced value before the new value is accepted (>=2)
//   TICK_DIV       clock cycles per animation step tick (>=2)
//
// Configuration macro:
//   TBIRD_TICK_EN  defined   -> tick comes from a TICK_DIV divider that
//                               restarts whenever switch changes
//                  undefined -> no divider; tick is high whenever reset_n is
//                               high, so the sequencer steps every clock
// ----------------------------------------------------------------------------
module tbird_switch_conditioner #(
    parameter int DEB_CYCLES = 4,
    parameter int TICK_DIV   = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       raw_left,
    input  logic       raw_right,
    input  logic       raw_hazard,
    input  logic       raw_brake,
    output logic [2:0] switch,
    output logic       switch_changed,
    output logic       tick
);

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    localparam int IDX_LEFT   = 0;
    localparam int IDX_RIGHT  = 1;
    localparam int IDX_HAZARD = 2;
    localparam int IDX_BRAKE  = 3;

    logic [3:0]       raw_vec;
    logic [3:0]       sync_meta_q;
    logic [3:0]       sync_q;
    logic [3:0]       deb_q;
    logic [3:0]       deb_d;
    logic [DEB_W-1:0] deb_cnt_q [4];
    logic [DEB_W-1:0] deb_cnt_d [4];
    logic [2:0]       switch_q;
    logic [2:0]       switch_d;
    logic             changed_q;
    logic             changed_d;

    assign raw_vec = {raw_brake, raw_hazard, raw_right, raw_left};

    // Two-flop synchroniser for every raw control.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
        end else begin
            sync_meta_q <= raw_vec;
            sync_q      <= sync_meta_q;
        end
    end

    // Per-input debounce. The counter measures how long the synchronised
    // value has disagreed with the accepted value; any agreement clears it,
    // so only an uninterrupted disagreement of DEB_CYCLES cycles is accepted.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i] = '0;
            if (sync_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    // Debounced state and counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            deb_q <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // Encoder: hazard, or both turn signals at once, lights both sides;
    // brake always rides on the top bit.
    always_comb begin
        switch_d = {deb_q[IDX_BRAKE], deb_q[IDX_LEFT], deb_q[IDX_RIGHT]};
        if (deb_q[IDX_HAZARD] || (deb_q[IDX_LEFT] && deb_q[IDX_RIGHT])) begin
            switch_d[1:0] = 2'b11;
        end
        changed_d = (switch_d != switch_q);
    end

    // Registered code plus a pulse marking the cycle it takes a new value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            switch_q  <= '0;
            changed_q <= 1'b0;
        end else begin
            switch_q  <= switch_d;
            changed_q <= changed_d;
        end
    end

    assign switch         = switch_q;
    assign switch_changed = changed_q;

`ifdef TBIRD_TICK_EN
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;

    // Step divider. The reload happens at the end of the switch_changed
    // cycle, so the first tick after a change lands exactly TICK_DIV cycles
    // after it.
    always_comb begin
        if (changed_q || (tick_cnt_q == TICK_LAST)) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
    end

    // Divider count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // A change pulse suppresses a tick that would fall on the same cycle.
    assign tick = (tick_cnt_q == TICK_LAST) && !changed_q;
`else
    localparam logic TICK_DIV_OK = (TICK_DIV >= 2);

    // Without the divider the sequencer steps on every clock out of reset.
    assign tick = reset_n & TICK_DIV_OK;
`endif

endmodule

// File: tb/tb_tbird_switch_conditioner.sv
// ----------------------------------------------------------------------------
// tb_tbird_switch_conditioner
//
// Scoreboard bench for the T-bird switch conditioner. A reference model
// watches the raw controls at every clock edge and predicts, from the
// debounce window and encoding rules, when the code changes and when ticks
// fall. Predictions are queued, and a monitor on the falling edge pops and
// compares them whenever the design pulses switch_changed or tick.
// ----------------------------------------------------------------------------
module tb_tbird_switch_conditioner;

    localparam int DEB  = 4;
    localparam int TDIV = 8;

    logic       clock      = 1'b0;
    logic       reset_n    = 1'b0;
    logic       raw_left   = 1'b0;
    logic       raw_right  = 1'b0;
    logic       raw_hazard = 1'b0;
    logic       raw_brake  = 1'b0;
    logic [2:0] switch;
    logic       switch_changed;
    logic       tick;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         edgeNo;
        logic [2:0] code;
    } swItem_t;

    swItem_t    swQ[$];
    int         tickQ[$];
    logic [3:0] hist[$];
    int         edgeNo;
    int         tickRef;
    logic [2:0] expSwitch;
    logic [3:0] debModel;

    tbird_switch_conditioner #(
        .DEB_CYCLES(DEB),
        .TICK_DIV  (TDIV)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .raw_left      (raw_left),
        .raw_right     (raw_right),
        .raw_hazard    (raw_hazard),
        .raw_brake     (raw_brake),
        .switch        (switch),
        .switch_changed(switch_changed),
        .tick          (tick)
    );

    always #5 clock = ~clock;

    // Encoding rule, bits of d are {brake, hazard, right, left}.
    function automatic logic [2:0] encodeModel(input logic [3:0] d);
        logic [1:0] turn;
        if (d[2] || (d[0] && d[1])) turn = 2'b11;
        else                        turn = {d[0], d[1]};
        return {d[3], turn};
    endfunction

    task automatic modelReset();
        edgeNo    = 0;
        tickRef   = -1;
        expSwitch = 3'b000;
        debModel  = 4'b0000;
        swQ.delete();
        tickQ.delete();
        hist.delete();
        for (int k = 0; k < DEB + 1; k++) hist.push_back(4'b0000);
    endtask

    // Reference model. An input is accepted once the raw value captured at
    // edges n-DEB-1 .. n-2 (seen through the two sync stages) all disagree
    // with the accepted value; the code register follows one edge later.
    initial begin : model
        logic [2:0] nowCode;
        logic       settle;
        modelReset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                modelReset();
            end else begin
                edgeNo++;
                hist.push_back({raw_brake, raw_hazard, raw_right, raw_left});
                if (hist.size() > DEB + 2) void'(hist.pop_front());
                nowCode = encodeModel(debModel);
                if (nowCode != expSwitch) begin
                    expSwitch = nowCode;
                    swQ.push_back('{edgeNo, nowCode});
                    tickRef = edgeNo;
                end
                for (int b = 0; b < 4; b++) begin
                    settle = 1'b1;
                    for (int k = 0; k < DEB; k++)
                        if (hist[k][b] == debModel[b]) settle = 1'b0;
                    if (settle) debModel[b] = ~debModel[b];
                end
                if (edgeNo > tickRef && ((edgeNo - tickRef) % TDIV) == 0)
                    tickQ.push_back(edgeNo);
            end
        end
    end

    // Monitor: compares the design against the queued predictions.
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (reset_n) begin
                checks++;
                if (switch !== expSwitch) begin
                    errors++;
                    $display("[TB] FAIL switchLevel edge %0d: got %b expected %b", edgeNo, switch, expSwitch);
                end
                while (swQ.size() > 0 && swQ[0].edgeNo < edgeNo) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL changedMissing: no pulse at edge %0d, expected code %b", swQ[0].edgeNo, swQ[0].code);
                    void'(swQ.pop_front());
                end
                if (switch_changed) begin
                    checks++;
                    if (swQ.size() > 0 && swQ[0].edgeNo == edgeNo) begin
                        if (swQ[0].code !== switch) begin
                            errors++;
                            $display("[TB] FAIL changedCode edge %0d: got %b expected %b", edgeNo, switch, swQ[0].code);
                        end
                        void'(swQ.pop_front());
                    end else begin
                        errors++;
                        $display("[TB] FAIL changedUnexpected edge %0d: got pulse expected none", edgeNo);
                    end
                end
`ifdef TBIRD_TICK_EN
                while (tickQ.size() > 0 && tickQ[0] < edgeNo) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL tickMissing: no tick at edge %0d", tickQ[0]);
                    void'(tickQ.pop_front());
                end
                if (tick) begin
                    checks++;
                    if (tickQ.size() > 0 && tickQ[0] == edgeNo) begin
                        void'(tickQ.pop_front());
                    end else begin
                        errors++;
                        $display("[TB] FAIL tickUnexpected edge %0d: got tick expected none", edgeNo);
                    end
                end
`else
                tickQ.delete();
                checks++;
                if (tick !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL tickConstant edge %0d: got %b expected 1", edgeNo, tick);
                end
`endif
            end
        end
    end

    task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    // Sets the raw controls and holds them for the given number of edges.
    task automatic applyStimulus(input logic l, input logic r, input logic h, input logic b, input int cycles);
        raw_left   = l;
        raw_right  = r;
        raw_hazard = h;
        raw_brake  = b;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic enterReset();
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("resetSwitch", switch, 3'b000);
        checkOutput("resetChanged", {2'b00, switch_changed}, 3'b000);
        checkOutput("resetTick", {2'b00, tick}, 3'b000);
    endtask

    task automatic leaveReset();
        @(negedge clock);
        #2 reset_n = 1'b1;
    endtask

    initial begin : driver
        #1;
        checkOutput("initSwitch", switch, 3'b000);
        checkOutput("initTick", {2'b00, tick}, 3'b000);
        repeat (3) @(negedge clock);
        leaveReset();

        // Right turn held, then released.
        applyStimulus(0, 1, 0, 0, 30);
        checkOutput("rightHeld", switch, 3'b001);
        applyStimulus(0, 0, 0, 0, 14);

        // Short glitches on left must be ignored.
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 10);
        applyStimulus(1, 0, 0, 0, 3);
        applyStimulus(0, 0, 0, 0, 10);
        checkOutput("glitchIgnored", switch, 3'b000);

        // Hazard, hazard with brake, both turns without hazard.
        applyStimulus(0, 0, 1, 0, 14);
        checkOutput("hazard", switch, 3'b011);
        applyStimulus(0, 0, 1, 1, 14);
        checkOutput("hazardBrake", switch, 3'b111);
        applyStimulus(0, 0, 0, 0, 14);
        applyStimulus(1, 1, 0, 0, 14);
        checkOutput("bothTurns", switch, 3'b011);
        applyStimulus(0, 0, 0, 0, 14);

        // Brake with left, then brake released.
        applyStimulus(1, 0, 0, 1, 20);
        checkOutput("brakeLeft", switch, 3'b110);
        applyStimulus(1, 0, 0, 0, 30);
        checkOutput("leftOnly", switch, 3'b010);

        // Reset mid-run while left is active.
        enterReset();
        repeat (2) @(negedge clock);
        leaveReset();

        // Reset in the middle of a debounce.
        applyStimulus(0, 1, 0, 0, 4);
        enterReset();
        leaveReset();
        applyStimulus(0, 0, 0, 0, 12);

        // Random segments with mixed glitch and stable lengths.
        for (int s = 0; s < 200; s++) begin
            logic [3:0] bits;
            bits = 4'($urandom_range(0, 15));
            applyStimulus(bits[0], bits[1], bits[2], bits[3], $urandom_range(1, 12));
        end

        applyStimulus(0, 0, 0, 0, 24);
        checkOutput("finalSwitch", switch, 3'b000);
        checks++;
        if (swQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL changedLeftover: got %0d pending expected 0", swQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
